// File: rtl/seq_div.sv
// rtl/seq_div.sv - 16-bit signed radix-2 restoring sequential divider with valid/ready handshake

module seq_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Magnitude datapath: dvd_mag shifts out dividend bits and shifts in quotient bits.
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   prem;
    logic [CW-1:0]    count;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             divisor_zero;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] dvd_next;

    // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (-v) : v;
    endfunction

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
    always_comb begin
        shifted   = {prem[WIDTH-1:0], dvd_mag[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_mag};
        q_bit     = ~trial[WIDTH];
        prem_next = q_bit ? trial : shifted;
        dvd_next  = {dvd_mag[WIDTH-2:0], q_bit};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next   = state;
        src_ready    = 1'b0;
        dst_valid    = 1'b0;
        accept       = 1'b0;
        divisor_zero = (divisor == '0);
        last_iter    = (count == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                src_ready = 1'b1;
                accept    = src_valid;
                if (src_valid) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                dst_valid = 1'b1;
                if (dst_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and sign-corrected result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_mag     <= '0;
            dvs_mag     <= '0;
            prem        <= '0;
            count       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                dvd_mag <= mag(dividend);
                dvs_mag <= mag(divisor);
                q_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_neg   <= dividend[WIDTH-1];
                prem    <= '0;
                count   <= '0;
                if (divisor_zero) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == CALC) begin
                dvd_mag <= dvd_next;
                prem    <= prem_next;
                count   <= count + CW'(1);
                if (last_iter) begin
                    quotient    <= q_neg ? (-dvd_next) : dvd_next;
                    remainder   <= r_neg ? (-prem_next[WIDTH-1:0]) : prem_next[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - randomized self-checking bench for seq_div against an arithmetic reference

module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        dst_valid;
    logic        dst_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    seq_div #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .dst_valid   (dst_valid),
        .dst_ready   (dst_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer division truncates toward zero, remainder takes the dividend's sign.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
            z = 1'b0;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one division, wait for the result, stall, hand off. Called at posedge+1.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int stall, input bit noise);
        int edges;
        check({tag, ":src_ready_idle"}, 32'(src_ready), 32'd1);
        src_valid = 1'b1;
        dividend  = a;
        divisor   = b;
        dst_ready = 1'b0;
        step();
        src_valid = 1'b0;
        edges = 0;
        while (!dst_valid && edges < 40) begin
            if (noise) begin
                src_valid = 1'($urandom);
                dividend  = 16'($urandom);
                divisor   = 16'($urandom);
                dst_ready = 1'($urandom);
            end
            step();
            edges++;
        end
        src_valid = 1'b0;
        dst_ready = 1'b0;
        check({tag, ":latency"}, 32'(edges), (b == 16'h0) ? 32'd0 : 32'd16);
        for (int i = 0; i < stall; i++) begin
            check({tag, ":hold_q"}, 32'(quotient), 32'(eq));
            check({tag, ":hold_srdy"}, 32'(src_ready), 32'd0);
            if (noise) begin
                dividend = 16'($urandom);
                divisor  = 16'($urandom);
            end
            step();
        end
        check({tag, ":dst_valid"}, 32'(dst_valid), 32'd1);
        check({tag, ":quotient"}, 32'(quotient), 32'(eq));
        check({tag, ":remainder"}, 32'(remainder), 32'(er));
        check({tag, ":div_by_zero"}, 32'(div_by_zero), 32'(ez));
        dst_ready = 1'b1;
        step();
        dst_ready = 1'b0;
        check({tag, ":dst_valid_drop"}, 32'(dst_valid), 32'd0);
        check({tag, ":src_ready_back"}, 32'(src_ready), 32'd1);
        check({tag, ":q_kept"}, 32'(quotient), 32'(eq));
    endtask

    task automatic rand_operand(output logic [15:0] v);
        logic [15:0] extremes [5];
        extremes[0] = 16'h8000;
        extremes[1] = 16'h7FFF;
        extremes[2] = 16'hFFFF;
        extremes[3] = 16'h0001;
        extremes[4] = 16'h0000;
        case ($urandom_range(0, 3))
            0: v = extremes[$urandom_range(0, 4)];
            1: v = 16'($signed(int'($urandom_range(0, 16)) - 8));
            default: v = 16'($urandom);
        endcase
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        bit          seen;

        rst       = 1'b1;
        src_valid = 1'b0;
        dividend  = '0;
        divisor   = '0;
        dst_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset:src_ready", 32'(src_ready), 32'd1);
        check("reset:dst_valid", 32'(dst_valid), 32'd0);
        check("reset:quotient", 32'(quotient), 32'd0);
        check("reset:remainder", 32'(remainder), 32'd0);
        check("reset:div_by_zero", 32'(div_by_zero), 32'd0);

        run_op("100/7",    16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 0, 1'b0);
        run_op("-100/7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 0, 1'b0);
        run_op("100/-7",   16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 0, 1'b0);
        run_op("-100/-7",  16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 0, 1'b0);
        run_op("7/0",      16'd7,    16'd0,    16'hFFFF, 16'h0007, 1'b1, 0, 1'b0);
        run_op("0/0",      16'd0,    16'd0,    16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op("min/-1",   16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 0, 1'b0);
        run_op("min/1",    16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 0, 1'b0);
        run_op("max/min",  16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 0, 1'b0);
        run_op("5/9",      16'd5,    16'd9,    16'h0000, 16'h0005, 1'b0, 0, 1'b0);
        run_op("1000/3bp", 16'd1000, 16'd3,    16'd333,  16'd1,    1'b0, 10, 1'b1);

        // Reset during iteration 8 of 1234/10.
        src_valid = 1'b1;
        dividend  = 16'd1234;
        divisor   = 16'd10;
        step();
        src_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst:dst_valid", 32'(dst_valid), 32'd0);
        check("midrst:src_ready", 32'(src_ready), 32'd1);
        check("midrst:quotient", 32'(quotient), 32'd0);
        check("midrst:remainder", 32'(remainder), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dst_valid) seen = 1'b1;
        end
        check("midrst:no_stale", 32'(seen), 32'd0);
        run_op("50/-6", 16'd50, 16'hFFFA, 16'hFFF8, 16'h0002, 1'b0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            rand_operand(a);
            rand_operand(b);
            model(a, b, eq, er, ez);
            run_op("rand", a, b, eq, er, ez, $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- 16-bit signed sequential divider, radix-2 restoring, one quotient bit per clock.
- Inverse companion to the team's sequential Booth multiplier; shares its register/shift/counter datapath style.
- Valid/ready handshake on both input and output; one division in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits; two's complement signed (must be >= 4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- src_valid  input  1  dividend/divisor valid.
- src_ready  output  1  block can accept an operation.
- dividend  input  WIDTH  signed dividend; sampled on accept only.
- divisor  input  WIDTH  signed divisor; sampled on accept only.
- dst_valid  output  1  quotient/remainder/div_by_zero valid.
- dst_ready  input  1  consumer takes result.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows dividend.
- div_by_zero  output  1  divisor was zero for this result.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-division): state=IDLE, src_ready=1, dst_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0, internal registers=0. Any in-flight operation is discarded with no output.
- States: IDLE, CALC, DONE.
  - src_ready = (state==IDLE).
  - dst_valid = (state==DONE).
- IDLE:
  - Accept on an edge with src_valid && src_ready.
  - On accept, register |dividend| and |divisor| as unsigned WIDTH-bit magnitudes. The magnitude of the most-negative value is 2^(WIDTH-1) unsigned.
  - Also register q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - If divisor!=0, go to CALC.
  - If divisor==0, go to DONE with quotient = all ones, remainder = dividend unchanged, div_by_zero=1. dst_valid is visible the cycle after accept.
- CALC, one iteration per edge:
  - Shift {partial_rem, dividend_mag} left by 1.
  - Trial-subtract divisor_mag from the partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; else restore and set the LSB to 0.
  - Counter increments.
  - On the edge completing iteration WIDTH (counter==WIDTH-1), register sign-corrected results into quotient/remainder (negate the quotient if q_neg, negate the remainder if r_neg), set div_by_zero=0, and go to DONE.
- Latency: dst_valid rises exactly WIDTH edges after the accept edge (16 for default), independent of operand values.
- DONE:
  - quotient, remainder and div_by_zero are held stable while dst_ready=0.
  - On an edge with dst_ready=1, go to IDLE; outputs keep their last values but dst_valid falls.
  - src_ready is 0 in DONE, so there is no accept in the same cycle as result handoff. Minimum issue interval is WIDTH+2 cycles.
- Overflow: -2^(WIDTH-1) / -1 gives quotient 0x8000 (wraps), remainder 0, div_by_zero=0. No flag is raised.
- Identity: dividend = quotient*divisor + remainder (mod 2^WIDTH) and |remainder| < |divisor| for all divisor!=0.
- Ignored inputs:
  - src_valid, dividend and divisor are ignored outside IDLE.
  - dst_ready is ignored outside DONE.
- Both operands zero: counts as div-by-zero. Quotient 0xFFFF, remainder 0, flag 1.

Test Plan:
- Reset, then 100/7 with dst_ready=1 -> dst_valid 16 cycles after accept; quotient=14 (0x000E), remainder=2, div_by_zero=0; src_ready back high the cycle after handoff.
- Sign combinations: -100/7 -> q=0xFFF2 (-14), r=0xFFFE (-2); 100/-7 -> q=0xFFF2, r=2; -100/-7 -> q=14, r=0xFFFE.
- 7/0 -> dst_valid the cycle after accept, q=0xFFFF, r=7, div_by_zero=1. Then 0/0 -> q=0xFFFF, r=0, div_by_zero=1.
- Boundaries:
  - -32768/-1 -> q=0x8000, r=0.
  - -32768/1 -> q=0x8000, r=0.
  - 32767/-32768 -> q=0, r=32767.
  - 5/9 -> q=0, r=5.
- Backpressure: 1000/3 with dst_ready=0 for 10 cycles after dst_valid -> q=333, r=1 held constant, src_ready=0 throughout. Inputs toggled during CALC/DONE do not change the result.
- Reset mid-operation: assert rst at iteration 8 of 1234/10 -> next cycle IDLE, dst_valid=0, q=r=0, and no stale result appears. A following 50/-6 returns q=0xFFF8 (-8), r=2.
